// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: sequences the shared-memory datapath one state per cycle,
// stalls on mem_ready and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [2:0]           alucontrol,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [1:0]           w_aluop;
  logic                 w_alu_en;
  logic                 w_retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_WIDTH'(1);
  end

  // Next state and per-state control; everything forced low while reset is held.
  always_comb begin
    w_next   = S_FETCH;
    w_aluop  = 2'b00;
    w_alu_en = 1'b0;
    w_retire = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb  = 2'b01;
        w_alu_en = 1'b1;
        irwrite  = mem_ready;
        pcen     = mem_ready;
        w_next   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb  = 2'b11;
        w_alu_en = 1'b1;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        w_alu_en = 1'b1;
        w_next   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b10;
        w_alu_en = 1'b1;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        w_alu_en = 1'b1;
        pcsrc    = 2'b01;
        pcen     = zero;
        w_retire = 1'b1;
      end
      S_ADDIEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        w_alu_en = 1'b1;
        w_next   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_JUMP: begin
        pcsrc    = 2'b10;
        pcen     = 1'b1;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      w_alu_en = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      illegal  = 1'b0;
    end
  end

  // ALU decode, only driven in states that actually use the ALU.
  always_comb begin
    alucontrol = 3'b000;
    if (w_alu_en) begin
      case (w_aluop)
        2'b00:   alucontrol = 3'b010;
        2'b01:   alucontrol = 3'b110;
        2'b10: begin
          case (funct)
            6'b100000: alucontrol = 3'b010;
            6'b100010: alucontrol = 3'b110;
            6'b100100: alucontrol = 3'b000;
            6'b100101: alucontrol = 3'b001;
            6'b101010: alucontrol = 3'b111;
            default:   alucontrol = 3'b010;
          endcase
        end
        default: alucontrol = 3'b010;
      endcase
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus a mid-instruction reset sequence.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal}
  localparam logic [15:0] C_ZERO    = 16'b0_0_0_0_0_0_0_00_00_0_000_0;
  localparam logic [15:0] C_FETCH_R = 16'b0_0_1_0_0_0_0_01_00_1_010_0;
  localparam logic [15:0] C_FETCH_W = 16'b0_0_0_0_0_0_0_01_00_0_010_0;
  localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_11_00_0_010_0;
  localparam logic [15:0] C_DEC_ILL = 16'b0_0_0_0_0_0_0_11_00_0_010_1;
  localparam logic [15:0] C_MEMADR  = 16'b0_0_0_0_0_0_1_10_00_0_010_0;
  localparam logic [15:0] C_MEMRD   = 16'b1_0_0_0_0_0_0_00_00_0_000_0;
  localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_1_1_0_00_00_0_000_0;
  localparam logic [15:0] C_MEMWR   = 16'b1_1_0_0_0_0_0_00_00_0_000_0;
  localparam logic [15:0] C_EX_ADD  = 16'b0_0_0_0_0_0_1_00_00_0_010_0;
  localparam logic [15:0] C_EX_SUB  = 16'b0_0_0_0_0_0_1_00_00_0_110_0;
  localparam logic [15:0] C_EX_AND  = 16'b0_0_0_0_0_0_1_00_00_0_000_0;
  localparam logic [15:0] C_EX_OR   = 16'b0_0_0_0_0_0_1_00_00_0_001_0;
  localparam logic [15:0] C_EX_SLT  = 16'b0_0_0_0_0_0_1_00_00_0_111_0;
  localparam logic [15:0] C_ALUWB   = 16'b0_0_0_1_0_1_0_00_00_0_000_0;
  localparam logic [15:0] C_BR_T    = 16'b0_0_0_0_0_0_1_00_01_1_110_0;
  localparam logic [15:0] C_BR_NT   = 16'b0_0_0_0_0_0_1_00_01_0_110_0;
  localparam logic [15:0] C_ADDIWB  = 16'b0_0_0_0_0_1_0_00_00_0_000_0;
  localparam logic [15:0] C_JUMP    = 16'b0_0_0_0_0_0_0_00_10_1_000_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mrdy;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] ir;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        n_iord, n_memwrite, n_irwrite, n_regdst, n_memtoreg, n_regwrite, n_alusrca, n_pcen, n_illegal;
  logic [1:0]  n_alusrcb, n_pcsrc;
  logic [2:0]  n_alucontrol;
  logic [3:0]  n_state;
  logic [2:0]  n_instret;

  logic [15:0] w_ctl;
  assign w_ctl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, pcen, alucontrol, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .state(state),
    .illegal(illegal), .instret(instret)
  );

  // Narrow counter instance exercises modulo wrap of instret.
  multicycle_ctrl #(.CNT_WIDTH(3)) u_dut_w (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(n_iord), .memwrite(n_memwrite), .irwrite(n_irwrite), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .regwrite(n_regwrite), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .pcsrc(n_pcsrc), .pcen(n_pcen), .alucontrol(n_alucontrol), .state(n_state),
    .illegal(n_illegal), .instret(n_instret)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic r, input logic [3:0] st, input logic [15:0] c, input logic [31:0] ir);
    vec_t v;
    v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.mrdy = r;
    v.st = st; v.ctl = c; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [15:0] ex, input logic [31:0] ir);
    add(0, RT, f, 0, 1, 4'd0, C_FETCH_R, ir);
    add(0, RT, f, 0, 1, 4'd1, C_DECODE,  ir);
    add(0, RT, f, 0, 1, 4'd6, ex,        ir);
    add(0, RT, f, 0, 1, 4'd7, C_ALUWB,   ir);
  endtask

  initial begin
    // reset, then lw with no stalls
    add(1, LW, 0, 0, 1, 4'd0, C_ZERO,    0);
    add(0, LW, 0, 0, 1, 4'd0, C_FETCH_R, 0);
    add(0, LW, 0, 0, 1, 4'd1, C_DECODE,  0);
    add(0, LW, 0, 0, 1, 4'd2, C_MEMADR,  0);
    add(0, LW, 0, 0, 1, 4'd3, C_MEMRD,   0);
    add(0, LW, 0, 0, 1, 4'd4, C_MEMWB,   0);
    add_rtype(6'b101010, C_EX_SLT, 1);
    add_rtype(6'b111111, C_EX_ADD, 2);
    // beq taken, with one fetch stall
    add(0, BEQ, 0, 0, 0, 4'd0, C_FETCH_W, 3);
    add(0, BEQ, 0, 0, 1, 4'd0, C_FETCH_R, 3);
    add(0, BEQ, 0, 0, 1, 4'd1, C_DECODE,  3);
    add(0, BEQ, 0, 1, 1, 4'd8, C_BR_T,    3);
    // beq not taken
    add(0, BEQ, 0, 0, 1, 4'd0, C_FETCH_R, 4);
    add(0, BEQ, 0, 0, 1, 4'd1, C_DECODE,  4);
    add(0, BEQ, 0, 0, 1, 4'd8, C_BR_NT,   4);
    // addi
    add(0, ADDI, 0, 0, 1, 4'd0,  C_FETCH_R, 5);
    add(0, ADDI, 0, 0, 1, 4'd1,  C_DECODE,  5);
    add(0, ADDI, 0, 0, 1, 4'd9,  C_MEMADR,  5);
    add(0, ADDI, 0, 0, 1, 4'd10, C_ADDIWB,  5);
    // illegal opcode, then j
    add(0, BAD, 0, 0, 1, 4'd0,  C_FETCH_R, 6);
    add(0, BAD, 0, 0, 1, 4'd1,  C_DEC_ILL, 6);
    add(0, JMP, 0, 0, 1, 4'd0,  C_FETCH_R, 6);
    add(0, JMP, 0, 0, 1, 4'd1,  C_DECODE,  6);
    add(0, JMP, 0, 0, 1, 4'd11, C_JUMP,    6);
    // sw with three wait cycles in MEMWR
    add(0, SW, 0, 0, 1, 4'd0, C_FETCH_R, 7);
    add(0, SW, 0, 0, 1, 4'd1, C_DECODE,  7);
    add(0, SW, 0, 0, 1, 4'd2, C_MEMADR,  7);
    add(0, SW, 0, 0, 0, 4'd5, C_MEMWR,   7);
    add(0, SW, 0, 0, 0, 4'd5, C_MEMWR,   7);
    add(0, SW, 0, 0, 0, 4'd5, C_MEMWR,   7);
    add(0, SW, 0, 0, 1, 4'd5, C_MEMWR,   7);
    // lw: mem_ready ignored in DECODE/MEMADR, one MEMRD stall
    add(0, LW, 0, 0, 1, 4'd0, C_FETCH_R, 8);
    add(0, LW, 0, 0, 0, 4'd1, C_DECODE,  8);
    add(0, LW, 0, 0, 0, 4'd2, C_MEMADR,  8);
    add(0, LW, 0, 0, 0, 4'd3, C_MEMRD,   8);
    add(0, LW, 0, 0, 1, 4'd3, C_MEMRD,   8);
    add(0, LW, 0, 0, 0, 4'd4, C_MEMWB,   8);
    add_rtype(6'b100010, C_EX_SUB, 9);
    add_rtype(6'b100100, C_EX_AND, 10);
    add_rtype(6'b100101, C_EX_OR,  11);
    add_rtype(6'b100000, C_EX_ADD, 12);
    add(0, SW, 0, 0, 1, 4'd0, C_FETCH_R, 13);

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].mrdy;
      #3;
      chk($sformatf("v%0d state", i),     32'(state),     32'(vecs[i].st));
      chk($sformatf("v%0d ctl", i),       32'(w_ctl),     32'(vecs[i].ctl));
      chk($sformatf("v%0d instret", i),   instret,        vecs[i].ir);
      chk($sformatf("v%0d instret_w", i), 32'(n_instret), vecs[i].ir & 32'h7);
      @(posedge clk); #1;
    end

    // sw in flight: reset asserted mid-MEMWR clears state and strobes without an edge
    op = SW; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    chk("pre_rst state", 32'(state), 32'd5);
    chk("pre_rst memwrite", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst state", 32'(state), 32'd0);
    chk("rst memwrite", 32'(memwrite), 32'd0);
    chk("rst instret", instret, 32'd0);
    chk("rst irwrite", 32'(irwrite), 32'd0);
    chk("rst pcen", 32'(pcen), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("rst irwrite rdy", 32'(irwrite), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst state", 32'(state), 32'd0);
    chk("post_rst irwrite", 32'(irwrite), 32'd1);
    chk("post_rst pcen", 32'(pcen), 32'd1);
    @(posedge clk); #1;
    chk("post_rst decode", 32'(state), 32'd1);
    chk("post_rst instret", instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Finite-state controller that sequences a shared-memory, multicycle MIPS datapath: one memory port, one ALU and the existing regfile/alu/mux2/flopr primitives, reused across cycles.
- Decodes opcode and funct and drives every datapath select and enable cycle by cycle.
- Stalls on a memory-ready handshake and counts retired instructions.
- Sits beside the datapath inside the multicycle `mips` top, replacing `controller`.

## Interface
- CNT_WIDTH, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH, instret 0
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag (1 when result == 0)
- mem_ready  in  1  memory completes current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write request
- irwrite  out  1  instruction register load enable
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  regfile write data: 0 = ALUOut, 1 = Data reg
- regwrite  out  1  regfile write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = A reg
- alusrcb  out  2  ALU B: 00 = B reg, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  PC next: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC register enable
- alucontrol  out  3  ALU operation code
- state  out  4  current state encoding (debug)
- illegal  out  1  one-cycle pulse on unsupported opcode
- instret  out  CNT_WIDTH  retired-instruction count

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH next cycle with all outputs 0.
- Every output not listed for a state is 0. No X is ever driven.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes branch target). Next state by op:
  - 100011 (lw) / 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other op → FETCH, with illegal=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Stay while mem_ready=0; otherwise go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1, held every cycle until mem_ready=1, then → FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JUMP: pcsrc=10, pcen=1 → FETCH.
- ALU decode:
  - aluop 00 → 010; aluop 01 → 110.
  - aluop 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other → 010.
- instret increments by 1 on the final cycle of each legal instruction: MEMWB, MEMWR with mem_ready=1, ALUWB, BRANCH (taken or not), ADDIWB, JUMP. It wraps modulo 2^CNT_WIDTH. Illegal opcodes do not count.

## Timing
- State and instret are registered. Outputs are decoded combinationally from state, plus mem_ready (FETCH/MEMWR gating), zero (BRANCH) and funct (EXECUTE).
- While reset=1: state=0, instret=0, all outputs 0, including irwrite and pcen. This holds even though FETCH would otherwise follow mem_ready.
- Reset asserted mid-instruction aborts it immediately. No regwrite, memwrite or pcen is issued after the asserting edge.
- Cycles per instruction with mem_ready held 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Handshake signals (iord, memwrite) stay stable throughout the wait.
- mem_ready is ignored in all other states.

## Test plan
- Reset: assert reset with state=MEMWR → state=0, memwrite=0, instret=0 on the same cycle, without a clock edge. Release with mem_ready=1 → irwrite=1, pcen=1 in the first cycle.
- lw with mem_ready=1 → states 0,1,2,3,4. MEMWB shows regwrite=1, memtoreg=1. instret increments 0→1 after MEMWB.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, iord=1 throughout. Exit to FETCH only after mem_ready=1; instret +1.
- R-type funct 101010 → alucontrol=111 in EXECUTE; ALUWB shows regdst=1. funct 111111 → alucontrol=010.
- beq with zero=1 → pcen=1, pcsrc=01 in BRANCH. With zero=0 → pcen=0. Both take 3 cycles and both increment instret.
- op=111111 → illegal=1 for one cycle in DECODE, next state FETCH, instret unchanged. Then j → JUMP shows pcsrc=10, pcen=1.
